uart_tx_slave: RTL and testbench

Memory-mapped UART transmitter sitting on the UART port of the platform slave bus mux. It accepts CPU/probe stores of bytes on the `MemoryBus` interface, buffers them in a small FIFO, and serializes them 8N1 onto a single `tx` line. It also returns status and divisor readback on the same bus result.

---
 rtl/uart_tx_slave_pkg.sv | 34 +++
 rtl/uart_tx_slave_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_slave.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_slave.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/uart_tx_slave_pkg.sv
// Bus types plus UART transmitter constants: register offsets, STATUS bit positions and FSM states.
// UART_TX_PARITY_EN adds the PARITY state to the FSM enum.
package MemoryBus;
  typedef struct packed {
    logic        mem_read;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;

  typedef logic [31:0] Result;
endpackage

package UartTx;
  localparam logic [1:0]  REG_DATA    = 2'd0;
  localparam logic [1:0]  REG_STATUS  = 2'd1;
  localparam logic [1:0]  REG_DIVISOR = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [15:0] MIN_DIVISOR = 16'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;
endpackage

// File: rtl/uart_tx_slave_if.sv
// Slave-mux bus port: word address, write enable, command and combinational read result.
// No flow control; every store is sampled on the clock edge it is presented.
interface uart_tx_slave_if;
  logic [29:0]      address;
  logic             we;
  MemoryBus::Cmd    cmd;
  MemoryBus::Result result;

  modport master (output address, we, cmd, input result);
  modport slave  (input address, we, cmd, output result);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with count/full/empty; head visible combinationally on data_o.
// A push when full is taken only if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) count_d = count_q + CW'(1);
    else if (rd_en && !wr_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN); start bit begins one edge after the store.
// No backpressure: stores to a full FIFO without a same-cycle pop are dropped and set sticky overflow.
module uart_tx_slave
  import UartTx::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] RESET_DIVISOR = 16'd104
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_slave_if.slave  bus,
  output logic            tx,
  output logic            tx_irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   div_q, div_d, div_eff;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    addr;
  logic          push_req, pop, bit_end;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [15:0]   cnt_ext, status;
  logic          unused_bits;

  assign addr     = bus.address[1:0];
  assign push_req = bus.we && (addr == REG_DATA) && bus.cmd.mask_byte[0];
  assign div_eff  = (div_q < MIN_DIVISOR) ? MIN_DIVISOR : div_q;
  assign bit_end  = (timer_q == '0);
  assign unused_bits = ^{bus.address[29:2], bus.cmd.write_data[31:16], bus.cmd.mask_byte[3:2]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .data_i  (bus.cmd.write_data[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (bus.we && addr == REG_DIVISOR) begin
      if (bus.cmd.mask_byte[0]) div_d[7:0]  = bus.cmd.write_data[7:0];
      if (bus.cmd.mask_byte[1]) div_d[15:8] = bus.cmd.write_data[15:8];
    end
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    else if (bus.we && addr == REG_STATUS && bus.cmd.mask_byte[0] && bus.cmd.write_data[STAT_OVF])
      ovf_d = 1'b0;
  end

  // Every bit start reloads the timer from the divisor as it stands now.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != IDLE && !bit_end) timer_d = timer_q - 16'd1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_data;
          state_d = START;
          tx_d    = 1'b0;
          timer_d = div_eff - 16'd1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
          timer_d = div_eff - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = div_eff - 16'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          timer_d = div_eff - 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_data;
            state_d = START;
            tx_d    = 1'b0;
            timer_d = div_eff - 16'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      div_q   <= RESET_DIVISOR;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_ext = 16'(fifo_count);

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = (state_q != IDLE);
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = ovf_q;
    status[15:8]       = cnt_ext[7:0];
  end

  always_comb begin
    bus.result = '0;
    if (bus.cmd.mem_read) begin
      case (addr)
        REG_STATUS:  bus.result = {16'b0, status};
        REG_DIVISOR: bus.result = {16'b0, div_q};
        default:     bus.result = '0;
      endcase
    end
  end

  assign tx     = tx_q;
  assign tx_irq = fifo_empty && (state_q == IDLE);
endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed bench for uart_tx_slave: frame timing, back-to-back bytes, overflow, divisor changes, reset.
module tb_uart_tx_slave;
  logic clk = 1'b0;
  logic rst_n;
  logic tx, tx_irq;
  int   tests = 0;
  int   failed = 0;
  logic [31:0] rd;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  uart_tx_slave_if bus();

  uart_tx_slave #(.FIFO_DEPTH(16), .RESET_DIVISOR(16'd104)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .tx     (tx),
    .tx_irq (tx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.address             = {28'b0, a};
    bus.we                  = 1'b1;
    bus.cmd.mem_read        = 1'b0;
    bus.cmd.mask_byte       = m;
    bus.cmd.write_data      = d;
    @(negedge clk);
    bus.we                  = 1'b0;
    bus.cmd.mask_byte       = 4'b0;
    bus.cmd.write_data      = 32'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address      = {28'b0, a};
    bus.cmd.mem_read = 1'b1;
    #1;
    d = bus.result;
    bus.cmd.mem_read = 1'b0;
  endtask

  // Samples tx once per cycle starting at the first negedge after the start-bit edge.
  task automatic check_frame(input logic [7:0] b, input int d, input string tag);
    logic [10:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^b, b, 1'b0};
`else
    fr = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int i = 0; i < NB * d; i++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i), {31'b0, tx}, {31'b0, fr[i / d]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.address = '0;
    bus.we = 1'b0;
    bus.cmd = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, tx_irq}, 32'd1);
    bus_read(2'd1, rd); check("rst_status", rd, 32'h0000_0004);
    bus_read(2'd2, rd); check("rst_div", rd, 32'd104);
    bus.address = 30'd2; #1;
    check("noread_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte 0x55 with D=4
    bus_write(2'd2, 32'd4, 4'b0011);
    bus_write(2'd0, 32'h55, 4'b0001);
    check("pre_start_tx", {31'b0, tx}, 32'd1);
    bus_read(2'd1, rd); check("queued_status", rd, 32'h0000_0100);
    check_frame(8'h55, 4, "f55");
    @(negedge clk);
    check("f55_irq", {31'b0, tx_irq}, 32'd1);
    bus_read(2'd1, rd); check("f55_idle_status", rd, 32'h0000_0004);

`ifdef UART_TX_PARITY_EN
    bus_write(2'd0, 32'h07, 4'b0001);
    check_frame(8'h07, 4, "f07par");
    @(negedge clk);
`endif

    // Three back-to-back bytes
    bus_write(2'd0, 32'h01, 4'b0001);
    fork
      begin
        bus_write(2'd0, 32'h02, 4'b0001);
        bus_write(2'd0, 32'h03, 4'b0001);
      end
      check_frame(8'h01, 4, "b2b1");
    join
    bus_read(2'd1, rd); check("b2b_cnt2", rd, 32'h0000_0201);
    check_frame(8'h02, 4, "b2b2");
    bus_read(2'd1, rd); check("b2b_cnt1", rd, 32'h0000_0101);
    check_frame(8'h03, 4, "b2b3");
    bus_read(2'd1, rd); check("b2b_cnt0", rd, 32'h0000_0005);
    @(negedge clk);
    check("b2b_irq", {31'b0, tx_irq}, 32'd1);

    // Overflow: fill 16 while busy, 17th dropped
    bus_write(2'd0, 32'hA5, 4'b0001);
    @(negedge clk);
    for (int k = 0; k < 17; k++) bus_write(2'd0, 32'h10 + k, 4'b0001);
    bus_read(2'd1, rd); check("ovf_set", rd, 32'h0000_100B);
    bus_write(2'd1, 32'h8, 4'b0001);
    bus_read(2'd1, rd); check("ovf_clear", rd, 32'h0000_1003);
    // Push lands on the edge where STOP ends and the head is popped
    repeat (NB * 4 - 19) @(negedge clk);
    bus_write(2'd0, 32'h3C, 4'b0001);
    bus_read(2'd1, rd); check("full_push_pop", rd, 32'h0000_1003);
    check("full_next_start", {31'b0, tx}, 32'd0);

    // Reset during DATA bit 3 of 0x10
    repeat (17) @(negedge clk);
    check("bit3_tx", {31'b0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'b0, tx}, 32'd1);
    check("async_rst_irq", {31'b0, tx_irq}, 32'd1);
    bus_read(2'd1, rd); check("async_rst_status", rd, 32'h0000_0004);
    bus_read(2'd2, rd); check("async_rst_div", rd, 32'd104);
    @(negedge clk);
    rst_n = 1'b1;

    // DIVISOR 0 clamps to 2 cycles per bit
    bus_write(2'd2, 32'd0, 4'b0011);
    bus_read(2'd2, rd); check("div0_read", rd, 32'd0);
    bus_write(2'd0, 32'h0F, 4'b0001);
    check("div0_pre_tx", {31'b0, tx}, 32'd1);
    check_frame(8'h0F, 2, "d2");
    @(negedge clk);
    check("d2_irq", {31'b0, tx_irq}, 32'd1);

    // DIVISOR 4 -> 8 during the start bit: start keeps 4, data bits last 8
    bus_write(2'd2, 32'd4, 4'b0011);
    bus_write(2'd0, 32'h01, 4'b0001);
    fork
      bus_write(2'd2, 32'd8, 4'b0011);
      for (int k = 0; k < 28; k++) begin
        @(negedge clk);
        check($sformatf("divchg_c%0d", k), {31'b0, tx},
              (k >= 4 && k < 12) ? 32'd1 : 32'd0);
      end
    join
    bus_read(2'd2, rd); check("divchg_read", rd, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
